// File: rtl/fconvi_mod_pkg.sv
// rtl/fconvi_mod_pkg.sv - shared constants, stage records and rounding helper for fconvi_mod
package fconvi_mod_pkg;

  typedef enum logic [1:0] {
    FMT_SNG = 2'd0,
    FMT_DBL = 2'd1,
    FMT_EXT = 2'd2
  } fmt_e;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam logic [63:0] SAT_S_MAX = 64'h7fff_ffff_ffff_ffff;
  localparam logic [63:0] SAT_S_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SAT_U_MAX = 64'hffff_ffff_ffff_ffff;
  localparam logic [63:0] SAT_U_MIN = 64'h0;

  localparam int SNG_EW = 8;
  localparam int DBL_EW = 11;
  localparam int EXT_EW = 16;
  localparam logic [15:0] SNG_BIAS = 16'd127;
  localparam logic [15:0] DBL_BIAS = 16'd1023;
  localparam logic [15:0] EXT_BIAS = 16'h7fff;

  typedef struct packed {
    logic        sign;
    logic        is_s;
    logic [1:0]  rm;
    logic        nan;
    logic        inf;
    logic [16:0] k;
    logic [63:0] sig;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic        is_s;
    logic [1:0]  rm;
    logic        nan;
    logic        ovf;
    logic [63:0] mag;
    logic        guard;
    logic        sticky;
  } s2_t;

  // Magnitude increment for sign-magnitude rounding.
  function automatic logic round_up(input logic [1:0] rm, input logic sign,
                                    input logic lsb, input logic g, input logic s);
    case (rm)
      RM_RNE:  return g & (s | lsb);
      RM_RDN:  return sign & (g | s);
      RM_RUP:  return ~sign & (g | s);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fconvi_shr.sv
// rtl/fconvi_shr.sv - 64-bit logical right shifter returning {result, guard, sticky}
module fconvi_shr (
  input  logic [63:0] data,
  input  logic [5:0]  amt,
  output logic [63:0] res,
  output logic        guard,
  output logic        sticky
);

  logic [127:0] wide;

  assign wide   = {data, 64'b0} >> amt;
  assign res    = wide[127:64];
  assign guard  = wide[63];
  assign sticky = |wide[62:0];

endmodule

// File: rtl/fconvi_mod.sv
// rtl/fconvi_mod.sv - FP to 64-bit integer converter, 3 stages; FCONVI_RMODE_EN adds rmode input
module fconvi_mod
  import fconvi_mod_pkg::*;
#(
  parameter logic [15:0] BIAS = 16'h7fff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clkEn,
  input  logic [81:0] A,
  input  logic        fromSNG,
  input  logic        fromDBL,
  input  logic        fromEXT,
  input  logic        isS,
`ifdef FCONVI_RMODE_EN
  input  logic [1:0]  rmode,
`endif
  output logic [64:0] res,
  output logic [1:0]  flg,
  output logic        alt
);

  logic [1:0] rm_in;
`ifdef FCONVI_RMODE_EN
  assign rm_in = rmode;
`else
  assign rm_in = RM_RTZ;
`endif

  logic unused_bit;
  assign unused_bit = A[32];

  fmt_e        fmt;
  logic        op_ok;
  logic [15:0] e;
  logic [15:0] bias;
  logic        is_max, frac_nz;
  s1_t         s1_d, s1_q;
  logic        v1, v2;

  assign op_ok = en & (fromSNG | fromDBL | fromEXT);

  always_comb begin
    fmt = fromEXT ? FMT_EXT : (fromDBL ? FMT_DBL : FMT_SNG);
    s1_d      = '0;
    s1_d.is_s = isS;
    s1_d.rm   = rm_in;
    e         = '0;
    bias      = SNG_BIAS;
    is_max    = 1'b0;
    frac_nz   = 1'b0;
    case (fmt)
      FMT_EXT: begin
        s1_d.sign = A[80];
        e         = {A[81], A[65], A[79:66]};
        bias      = BIAS;
        s1_d.sig  = {A[64:33], A[31:0]};
        is_max    = &e;
        frac_nz   = |s1_d.sig[62:0];
      end
      FMT_DBL: begin
        s1_d.sign = A[63];
        e         = {{(EXT_EW-DBL_EW){1'b0}}, A[62], A[64], A[61:53]};
        bias      = DBL_BIAS;
        s1_d.sig  = (e != 16'd0) ? {1'b1, A[52:33], A[31:0], 11'b0} : 64'd0;
        is_max    = &e[DBL_EW-1:0];
        frac_nz   = |{A[52:33], A[31:0]};
      end
      default: begin
        s1_d.sign = A[31];
        e         = {{(EXT_EW-SNG_EW){1'b0}}, A[30:23]};
        s1_d.sig  = (e != 16'd0) ? {1'b1, A[22:0], 40'b0} : 64'd0;
        is_max    = &e[SNG_EW-1:0];
        frac_nz   = |A[22:0];
      end
    endcase
    s1_d.k   = {1'b0, e} - {1'b0, bias};
    s1_d.nan = is_max & frac_nz;
    s1_d.inf = is_max & ~frac_nz;
  end

  // Stage 2: position the binary point at bit 0 of the magnitude.
  logic        k_neg, k_big, k_m1;
  logic [5:0]  amt;
  logic [63:0] sh_res;
  logic        sh_g, sh_s;
  s2_t         s2_d, s2_q;

  assign k_neg = s1_q.k[16];
  assign k_big = ~k_neg & (|s1_q.k[15:6]);
  assign k_m1  = (s1_q.k == 17'h1ffff);
  assign amt   = 6'd63 - s1_q.k[5:0];

  fconvi_shr u_shr (
    .data   (s1_q.sig),
    .amt    (amt),
    .res    (sh_res),
    .guard  (sh_g),
    .sticky (sh_s)
  );

  always_comb begin
    s2_d        = '0;
    s2_d.sign   = s1_q.sign;
    s2_d.is_s   = s1_q.is_s;
    s2_d.rm     = s1_q.rm;
    s2_d.nan    = s1_q.nan;
    s2_d.ovf    = k_big | s1_q.inf;
    if (k_neg) begin
      s2_d.guard  = k_m1 & s1_q.sig[63];
      s2_d.sticky = k_m1 ? |s1_q.sig[62:0] : |s1_q.sig;
    end else if (!k_big) begin
      s2_d.mag    = sh_res;
      s2_d.guard  = sh_g;
      s2_d.sticky = sh_s;
    end
  end

  // Stage 3: round, range-check against the target type, then saturate.
  logic        inc, ovf;
  logic [64:0] rmag;
  logic [63:0] r_d;
  logic [1:0]  f_d;

  always_comb begin
    inc  = round_up(s2_q.rm, s2_q.sign, s2_q.mag[0], s2_q.guard, s2_q.sticky);
    rmag = {1'b0, s2_q.mag} + {64'd0, inc};
    if (s2_q.is_s)
      ovf = s2_q.ovf | rmag[64] | (~s2_q.sign & rmag[63]) |
            (s2_q.sign & rmag[63] & (|rmag[62:0]));
    else
      ovf = s2_q.ovf | rmag[64] | (s2_q.sign & (|rmag));
    f_d = {1'b0, s2_q.guard | s2_q.sticky};
    r_d = s2_q.sign ? (64'd0 - rmag[63:0]) : rmag[63:0];
    if (s2_q.nan) begin
      r_d = s2_q.is_s ? SAT_S_MIN : SAT_U_MIN;
      f_d = 2'b10;
    end else if (ovf) begin
      if (s2_q.is_s) r_d = s2_q.sign ? SAT_S_MIN : SAT_S_MAX;
      else           r_d = s2_q.sign ? SAT_U_MIN : SAT_U_MAX;
      f_d = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      res  <= '0;
      flg  <= '0;
      alt  <= 1'b0;
    end else if (clkEn) begin
      v1   <= op_ok;
      s1_q <= s1_d;
      v2   <= v1;
      s2_q <= s2_d;
      alt  <= v2;
      res  <= {1'b0, r_d};
      flg  <= f_d;
    end
  end

endmodule

// File: tb/tb_fconvi_mod.sv
// tb/tb_fconvi_mod.sv - directed self-checking bench for fconvi_mod
module tb_fconvi_mod;

  logic        clk = 1'b0;
  logic        rst, en, clkEn, fromSNG, fromDBL, fromEXT, isS;
  logic [81:0] A;
  logic [64:0] res;
  logic [1:0]  flg;
  logic        alt;
  logic [1:0]  rm_tb;
  int          tests = 0;
  int          fails = 0;

  fconvi_mod dut (
    .clk(clk), .rst(rst), .en(en), .clkEn(clkEn), .A(A),
    .fromSNG(fromSNG), .fromDBL(fromDBL), .fromEXT(fromEXT), .isS(isS),
`ifdef FCONVI_RMODE_EN
    .rmode(rm_tb),
`endif
    .res(res), .flg(flg), .alt(alt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [81:0] psng(input logic [31:0] b);
    logic [81:0] a;
    a = '0;
    a[31:0] = b;
    return a;
  endfunction

  function automatic logic [81:0] pdbl(input logic [63:0] b);
    logic [81:0] a;
    a = '0;
    a[63] = b[63]; a[62] = b[62]; a[64] = b[61];
    a[61:53] = b[60:52]; a[52:33] = b[51:32]; a[31:0] = b[31:0];
    return a;
  endfunction

  function automatic logic [81:0] pext(input logic s, input logic [15:0] e, input logic [63:0] m);
    logic [81:0] a;
    a = '0;
    a[80] = s; a[81] = e[15]; a[65] = e[14]; a[79:66] = e[13:0];
    a[64:33] = m[63:32]; a[31:0] = m[31:0];
    return a;
  endfunction

  task automatic drive(input logic [81:0] a, input logic [2:0] fmt, input logic s);
    A = a; fromEXT = fmt[2]; fromDBL = fmt[1]; fromSNG = fmt[0]; isS = s; en = 1'b1;
  endtask

  // fmt = {EXT, DBL, SNG}; single op, result checked after the third edge.
  task automatic op(input string tag, input logic [81:0] a, input logic [2:0] fmt,
                    input logic s, input logic [63:0] er, input logic [1:0] ef);
    @(negedge clk); drive(a, fmt, s);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, ".alt"}, {64'd0, alt}, 65'd1);
    check({tag, ".res"}, res, {1'b0, er});
    check({tag, ".flg"}, {63'd0, flg}, {63'd0, ef});
    @(negedge clk);
    check({tag, ".alt_off"}, {64'd0, alt}, 65'd0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clkEn = 1'b1; A = '0; rm_tb = 2'b01;
    fromSNG = 1'b0; fromDBL = 1'b0; fromEXT = 1'b0; isS = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst.alt", {64'd0, alt}, 65'd0);
    check("rst.res", res, 65'd0);
    check("rst.flg", {63'd0, flg}, 65'd0);
    rst = 1'b1;

    op("sng_3p75", psng(32'h4070_0000), 3'b001, 1'b0, 64'd3, 2'b01);
    op("dbl_m1", pdbl(64'hbff0_0000_0000_0000), 3'b010, 1'b1, 64'hffff_ffff_ffff_ffff, 2'b00);
    op("ext_2p64", pext(1'b0, 16'h803f, 64'h8000_0000_0000_0000), 3'b100, 1'b0,
       64'hffff_ffff_ffff_ffff, 2'b10);
    op("ext_m2p63", pext(1'b1, 16'h803e, 64'h8000_0000_0000_0000), 3'b100, 1'b1,
       64'h8000_0000_0000_0000, 2'b00);
    op("sng_nan", psng(32'h7fc0_0000), 3'b001, 1'b1, 64'h8000_0000_0000_0000, 2'b10);
    op("sng_nan_u", psng(32'h7fc0_0000), 3'b001, 1'b0, 64'd0, 2'b10);
    op("sng_m0p5_u", psng(32'hbf00_0000), 3'b001, 1'b0, 64'd0, 2'b01);
    op("sng_m1_u", psng(32'hbf80_0000), 3'b001, 1'b0, 64'd0, 2'b10);
    op("dbl_2p63_s", pdbl(64'h43e0_0000_0000_0000), 3'b010, 1'b1, 64'h7fff_ffff_ffff_ffff, 2'b10);
    op("dbl_2p63_u", pdbl(64'h43e0_0000_0000_0000), 3'b010, 1'b0, 64'h8000_0000_0000_0000, 2'b00);
    op("sng_denorm", psng(32'h0000_0001), 3'b001, 1'b1, 64'd0, 2'b00);
    op("sng_minf_s", psng(32'hff80_0000), 3'b001, 1'b1, 64'h8000_0000_0000_0000, 2'b10);
    op("prio_ext", pext(1'b0, 16'h8000, 64'hc000_0000_0000_0000), 3'b111, 1'b1, 64'd3, 2'b00);
`ifdef FCONVI_RMODE_EN
    rm_tb = 2'b00; op("rne_2p5", psng(32'h4020_0000), 3'b001, 1'b0, 64'd2, 2'b01);
    rm_tb = 2'b11; op("rup_2p5", psng(32'h4020_0000), 3'b001, 1'b0, 64'd3, 2'b01);
    rm_tb = 2'b10; op("rdn_m2p5", psng(32'hc020_0000), 3'b001, 1'b1, 64'hffff_ffff_ffff_fffd, 2'b01);
    rm_tb = 2'b01; op("rtz_m2p5", psng(32'hc020_0000), 3'b001, 1'b1, 64'hffff_ffff_ffff_fffe, 2'b01);
`endif

    // Back-to-back issue of 1.0, 2.0, 5.0 with a two-cycle stall after the third.
    @(negedge clk); drive(psng(32'h3f80_0000), 3'b001, 1'b1);
    @(negedge clk); drive(psng(32'h4000_0000), 3'b001, 1'b1);
    @(negedge clk); drive(psng(32'h40a0_0000), 3'b001, 1'b1);
    @(negedge clk); en = 1'b0; clkEn = 1'b0;
    check("stall.e3.alt", {64'd0, alt}, 65'd1);
    check("stall.e3.res", res, 65'd1);
    @(negedge clk);
    check("stall.e4.res", res, 65'd1);
    @(negedge clk); clkEn = 1'b1;
    check("stall.e5.alt", {64'd0, alt}, 65'd1);
    check("stall.e5.res", res, 65'd1);
    @(negedge clk);
    check("stall.e6.res", res, 65'd2);
    @(negedge clk);
    check("stall.e7.alt", {64'd0, alt}, 65'd1);
    check("stall.e7.res", res, 65'd5);
    @(negedge clk);
    check("stall.e8.alt", {64'd0, alt}, 65'd0);

    // Reset while two ops remain in flight behind a visible result.
    @(negedge clk); drive(psng(32'h3f80_0000), 3'b001, 1'b1);
    @(negedge clk); drive(psng(32'h4000_0000), 3'b001, 1'b1);
    @(negedge clk); drive(psng(32'h40a0_0000), 3'b001, 1'b1);
    @(negedge clk); en = 1'b0;
    check("rstfl.pre.alt", {64'd0, alt}, 65'd1);
    rst = 1'b0;
    #1;
    check("rstfl.alt", {64'd0, alt}, 65'd0);
    check("rstfl.res", res, 65'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstfl.stale", {64'd0, alt}, 65'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fconvi_mod.md
# fconvi_mod

Floating-point to integer converter, the inverse of the integer-to-float path in the FP math unit. Takes one packed single, double or extended operand in the register-file FP layout and produces a 64-bit signed or unsigned integer with invalid/inexact flags. Three-stage pipeline stalled by `clkEn`, issued from the FP execution port alongside the other math conversion units.

## Interface
- `BIAS`, 16'h7fff: internal extended exponent bias.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `en`  in  1  operation valid this cycle.
- `clkEn`  in  1  pipeline advance; when low, every register holds.
- `A`  in  82  packed FP operand.
- `fromSNG`, `fromDBL`, `fromEXT`  in  1 each  source format; one-hot.
- `isS`  in  1  signed result when 1, unsigned when 0.
- `res`  out  65  `[63:0]` integer result; `[64]` always 0.
- `flg`  out  2  `[0]` inexact, `[1]` invalid.
- `alt`  out  1  result valid.

## Operation
- Unpack, stage 1:
  - SNG: sign `A[31]`, exponent `A[30:23]` (bias 127), fraction `A[22:0]`.
  - DBL: sign `A[63]`, exponent `{A[62],A[64],A[61:53]}` (bias 1023), fraction `{A[52:33],A[31:0]}`.
  - EXT: sign `A[80]`, exponent `{A[81],A[65],A[79:66]}` (bias 0x7fff), explicit 64-bit significand `{A[64:33],A[31:0]}`.
  - SNG/DBL: exponent field zero → value 0 (denormals flush, no flag change). Otherwise implicit 1 is prepended.
  - All formats: significand is left-justified to 64 bits. Signed 17-bit unbiased exponent `k` is computed.
  - More than one `from*` set: priority EXT > DBL > SNG. None set: treated as `en=0`.
- Shift, stage 2:
  - 0 ≤ k ≤ 63: logical right shift by 63−k, keeping guard bit and sticky OR of the discarded bits.
  - k < 0: integer part 0; guard = (k == −1); sticky = remaining bits.
  - k ≥ 64: overflow.
- Round/saturate, stage 3:
  - Round the magnitude, then negate if sign.
  - Inexact = guard | sticky.
  - Overflow detection uses the rounded magnitude:
    - unsigned: > 2^64−1, or negative and nonzero after rounding.
    - signed: > 2^63−1 positive, > 2^63 negative.
  - Saturation values:
    - unsigned: all-ones for positive overflow, 0 for negative.
    - signed: 0x7fff_ffff_ffff_ffff or 0x8000_0000_0000_0000.
  - NaN (max exponent, nonzero fraction): signed 0x8000_0000_0000_0000, unsigned 0, invalid=1.
  - Inf: treated as overflow.
  - Invalid forces inexact=0.
  - −2^63 signed is exact and valid.

## Timing
- Latency is 3 enabled edges: operand sampled at edge 1, `res`/`flg`/`alt` valid after edge 3.
- Throughput is one operation per enabled cycle.
- `alt` is `en` delayed three enabled edges, with the same stall behaviour as the data.
- `clkEn` low freezes every stage, including the valid bits and outputs. An operation already in flight completes after the same number of enabled edges.
- `rst` low immediately clears all stage valids, `alt`=0, `res`=0, `flg`=0. Operations in flight are discarded.
- First enabled edge after `rst` rises may capture a new operation.

## Configuration
- `FCONVI_RMODE_EN` defined:
  - Adds input port `rmode[1:0]`, sampled with `A` and piped alongside it.
  - Encodings: 00 nearest-even, 01 toward zero, 10 toward −inf, 11 toward +inf.
- Undefined:
  - No `rmode` port; always round toward zero (C cast semantics).
  - Inexact is still reported.

## Structure
- Shared package: format-select encoding, rounding-mode constants, the saturation constants and per-format bias/exponent-width constants. `ptype` codes stay in the existing struct header.
- One sub-module, `fconvi_shr`: 64-bit right shifter producing {result, guard, sticky}. Used in stage 2.

## Test plan
- SNG 0x4070_0000 (3.75), isS=0, clkEn held high → after 3 edges `res`=3, `flg`=01, `alt`=1 for one cycle.
- DBL −1.0 (A[63]=1, A[62]=0, A[64]=1, A[61:53]=0x1ff, fraction 0), isS=1 → `res[63:0]`=0xffff_ffff_ffff_ffff, `flg`=00.
- EXT 2^64 (exponent 0x803f, significand 0x8000…0), isS=0 → `res[63:0]`=0xffff_ffff_ffff_ffff, `flg`=10.
- Sign boundary and NaN:
  - EXT −2^63, isS=1 → 0x8000_0000_0000_0000, `flg`=00.
  - SNG 0x7fc0_0000 (NaN), isS=1 → 0x8000_0000_0000_0000, `flg`=10.
- Back-to-back issue with `clkEn` dropped two cycles mid-stream → each result appears once, in order, delayed by exactly the stalled cycles.
- Reset while two ops are in flight → `alt`=0 immediately, no stale result after release.
- With `FCONVI_RMODE_EN`: 2.5 → RNE 2, toward +inf 3.
- With `FCONVI_RMODE_EN`: −2.5 → toward −inf −3, toward zero −2.
